// File: rtl/debounced_input_pio_pkg.sv
// Shared constants for the debounced input PIO: register map
// and bit positions of the falling-edge enables.
package debounced_input_pio_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_IRQMASK = 2'd1;
    localparam logic [1:0] REG_CAPTURE = 2'd2;
    localparam logic [1:0] REG_EDGE_EN = 2'd3;

    localparam int unsigned FALL_EN_LSB = 16;
    localparam int unsigned MAX_WIDTH   = 16;

    localparam int unsigned BUS_DW = 32;

endpackage

// File: rtl/debounced_input_pio_if.sv
// Avalon-MM slave bus of the debounced input PIO
// (fixed read latency of one cycle).
interface debounced_input_pio_if;
    import debounced_input_pio_pkg::*;

    logic [1:0]        address;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [BUS_DW-1:0] writedata;
    logic [BUS_DW-1:0] readdata;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata
    );

endinterface

// File: rtl/debounced_input_pio_debounce_channel.sv
// One input channel: synchroniser chain, polarity fix,
// stability counter, debounced level and edge pulses.
module debounce_channel
    import debounced_input_pio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter bit          INVERT          = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   s;
    logic                   accept;

    // Sync flops reset to the idle pin level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{INVERT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1] ^ INVERT;

    always_comb begin
        cnt_d  = '0;
        db_d   = db_q;
        accept = 1'b0;
        if (s != db_q) begin
            if (cnt_q == CNT_MAX) begin
                accept = 1'b1;
                db_d   = s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign db_o   = db_q;
    assign rise_o = accept & s;
    assign fall_o = accept & ~s;

endmodule

// File: rtl/debounced_input_pio.sv
// Avalon-MM input PIO with per-bit debounce, programmable
// edge capture and a maskable level interrupt.
module debounced_input_pio
    import debounced_input_pio_pkg::*;
#(
    parameter int unsigned     WIDTH           = 4,
    parameter int unsigned     DEBOUNCE_CYCLES = 500000,
    parameter int unsigned     SYNC_STAGES     = 2,
    parameter logic [WIDTH-1:0] INVERT_MASK    = {WIDTH{1'b1}}
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     pins_in,
    debounced_input_pio_if.slave bus,
    output logic                 irq
);

    localparam logic [BUS_DW-1:0] USED_WD =
        (BUS_DW'({WIDTH{1'b1}}) << FALL_EN_LSB) | BUS_DW'({WIDTH{1'b1}});

    logic [WIDTH-1:0]  db, rise, fall, cap_set;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [WIDTH-1:0]  cap_q, cap_d;
    logic [WIDTH-1:0]  rise_en_q, rise_en_d;
    logic [WIDTH-1:0]  fall_en_q, fall_en_d;
    logic [BUS_DW-1:0] readdata_q, readdata_d;
    logic [BUS_DW-1:0] rdata;
    logic              irq_q, irq_d;
    logic              wr_en, rd_en;
    logic              unused_wd;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES),
            .INVERT         (INVERT_MASK[i])
        ) u_ch (
            .clk   (clk),
            .rst_n (reset_n),
            .pin_i (pins_in[i]),
            .db_o  (db[i]),
            .rise_o(rise[i]),
            .fall_o(fall[i])
        );
    end

    assign wr_en     = bus.chipselect & bus.write;
    assign rd_en     = bus.chipselect & bus.read;
    assign cap_set   = (rise & rise_en_q) | (fall & fall_en_q);
    assign unused_wd = ^(bus.writedata & ~USED_WD);

    // Read mux sees pre-write state, so read+write returns the old value.
    always_comb begin
        rdata = '0;
        unique case (1'b1)
            (bus.address == REG_DATA):    rdata[WIDTH-1:0] = db;
            (bus.address == REG_IRQMASK): rdata[WIDTH-1:0] = mask_q;
            (bus.address == REG_CAPTURE): rdata[WIDTH-1:0] = cap_q;
            (bus.address == REG_EDGE_EN): begin
                rdata[WIDTH-1:0]                 = rise_en_q;
                rdata[FALL_EN_LSB +: WIDTH]      = fall_en_q;
            end
            default: rdata = '0;
        endcase
    end

    // A new edge in the same cycle as its W1C clear keeps the bit set.
    always_comb begin
        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        cap_d     = cap_q | cap_set;
        if (wr_en) begin
            unique case (1'b1)
                (bus.address == REG_IRQMASK): mask_d = bus.writedata[WIDTH-1:0];
                (bus.address == REG_CAPTURE):
                    cap_d = (cap_q & ~bus.writedata[WIDTH-1:0]) | cap_set;
                (bus.address == REG_EDGE_EN): begin
                    rise_en_d = bus.writedata[WIDTH-1:0];
                    fall_en_d = bus.writedata[FALL_EN_LSB +: WIDTH];
                end
                default: ;
            endcase
        end
        readdata_d = rd_en ? rdata : readdata_q;
        irq_d      = |(cap_q & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q     <= '0;
            cap_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_debounced_input_pio.sv
// Bench for debounced_input_pio: window-based reference model
// checked every cycle, plus directed scenarios with literal results.
module tb_debounced_input_pio;
    import debounced_input_pio_pkg::*;

    localparam int W = 4;
    localparam int D = 4;
    localparam int S = 2;
    localparam logic [W-1:0] INV = 4'b0011;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] pins = INV;
    logic         irq;
    int           n_tests = 0;
    int           n_fail = 0;

    debounced_input_pio_if bus ();

    debounced_input_pio #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES    (S),
        .INVERT_MASK    (INV)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .pins_in(pins),
        .bus    (bus),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference model: a level is accepted once the pin, seen S cycles late,
    // has held the opposite of the accepted level for D consecutive samples.
    logic [W-1:0] m_hist [S+D];
    logic [W-1:0] m_db, m_mask, m_cap, m_ren, m_fen;
    logic [31:0]  m_rd;
    logic         m_irq;
    logic [W-1:0] inv_v;

    always @(posedge clk) begin
        logic [W-1:0] nd, rs, fl, st;
        logic [31:0]  rv;
        bit           hold;
        inv_v = INV;
        if (!reset_n) begin
            for (int k = 0; k < S + D; k++) m_hist[k] = inv_v;
            m_db = '0; m_mask = '0; m_cap = '0;
            m_ren = '0; m_fen = '0; m_rd = '0; m_irq = 1'b0;
        end else begin
            nd = m_db;
            for (int i = 0; i < W; i++) begin
                hold = 1'b1;
                for (int j = 0; j < D; j++)
                    if ((m_hist[S-1+j][i] ^ inv_v[i]) == m_db[i]) hold = 1'b0;
                if (hold) nd[i] = ~m_db[i];
            end
            rs = nd & ~m_db;
            fl = ~nd & m_db;
            st = (rs & m_ren) | (fl & m_fen);
            case (bus.address)
                2'd0:    rv = 32'(m_db);
                2'd1:    rv = 32'(m_mask);
                2'd2:    rv = 32'(m_cap);
                default: rv = 32'(m_ren) | (32'(m_fen) << 16);
            endcase
            if (bus.chipselect && bus.read) m_rd = rv;
            m_irq = |(m_cap & m_mask);
            if (bus.chipselect && bus.write && bus.address == 2'd2)
                m_cap = (m_cap & ~bus.writedata[W-1:0]) | st;
            else
                m_cap = m_cap | st;
            if (bus.chipselect && bus.write) begin
                if (bus.address == 2'd1) m_mask = bus.writedata[W-1:0];
                if (bus.address == 2'd3) begin
                    m_ren = bus.writedata[W-1:0];
                    m_fen = bus.writedata[16 +: W];
                end
            end
            for (int k = S + D - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = pins;
            m_db = nd;
        end
    end

    always @(posedge clk) begin
        #1;
        check("cyc_irq", 32'(irq), 32'(m_irq));
        check("cyc_readdata", bus.readdata, m_rd);
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        bus.chipselect = 1'b1; bus.write = 1'b1;
        bus.address = a; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write = 1'b0;
    endtask

    task automatic rd(logic [1:0] a, output logic [31:0] d);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.read = 1'b0;
        d = bus.readdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int          n;
        bus.address = '0; bus.chipselect = 1'b0;
        bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
        tick(3);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_readdata", bus.readdata, 32'h0);
        reset_n = 1'b1;
        tick(20);
        rd(REG_DATA, v);    check("t1_data", v, 32'h0);
        rd(REG_CAPTURE, v); check("t1_cap", v, 32'h0);
        check("t1_irq", 32'(irq), 32'h0);

        wr(REG_EDGE_EN, 32'h0000_000F);
        wr(REG_IRQMASK, 32'hFFFF_FFFF);
        rd(REG_EDGE_EN, v); check("t2_edge_rb", v, 32'h0000_000F);
        rd(REG_IRQMASK, v); check("t2_mask_width", v, 32'h0000_000F);
        pins = 4'b0010; tick(3); pins = 4'b0011; tick(10);
        rd(REG_DATA, v);    check("t2_glitch_data", v, 32'h0);
        rd(REG_CAPTURE, v); check("t2_glitch_cap", v, 32'h0);
        check("t2_irq", 32'(irq), 32'h0);

        pins = 4'b0010;
        n = 0;
        while (!irq && n < 12) begin tick(1); n++; end
        check("t3_irq_latency", 32'(n), 32'd7);
        rd(REG_DATA, v);    check("t3_data", v, 32'h1);
        rd(REG_CAPTURE, v); check("t3_cap", v, 32'h1);

        wr(REG_CAPTURE, 32'h1);
        check("t4_irq_hold", 32'(irq), 32'h1);
        tick(1);
        check("t4_irq_clr", 32'(irq), 32'h0);
        rd(REG_CAPTURE, v); check("t4_cap_clr", v, 32'h0);
        pins = 4'b0110; tick(5);
        wr(REG_CAPTURE, 32'h4);
        rd(REG_CAPTURE, v); check("t4_set_wins", v, 32'h4);
        check("t4_irq_set", 32'(irq), 32'h1);

        wr(REG_EDGE_EN, 32'h0);
        pins = 4'b0011; tick(10);
        wr(REG_CAPTURE, 32'hF);
        rd(REG_CAPTURE, v); check("t5_cap_empty", v, 32'h0);
        wr(REG_EDGE_EN, 32'h0001_0000);
        rd(REG_EDGE_EN, v); check("t5_edge_rb", v, 32'h0001_0000);
        pins = 4'b0010; tick(10);
        rd(REG_CAPTURE, v); check("t5_press_nocap", v, 32'h0);
        pins = 4'b0011; tick(10);
        rd(REG_CAPTURE, v); check("t5_release_cap", v, 32'h1);
        check("t5_irq", 32'(irq), 32'h1);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.write = 1'b1;
        bus.address = REG_IRQMASK; bus.writedata = 32'h5;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        check("t5_rw_old", bus.readdata, 32'hF);
        rd(REG_IRQMASK, v); check("t5_rw_new", v, 32'h5);
        wr(REG_IRQMASK, 32'hE);
        tick(1);
        check("t5_irq_masked", 32'(irq), 32'h0);
        wr(REG_DATA, 32'hF);
        rd(REG_DATA, v); check("t5_data_ro", v, 32'h0);

        wr(REG_CAPTURE, 32'hF);
        pins = 4'b1011; tick(4);
        reset_n = 1'b0; tick(2);
        check("t6_rst_readdata", bus.readdata, 32'h0);
        check("t6_rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        tick(5);
        rd(REG_DATA, v); check("t6_not_early", v, 32'h0);
        rd(REG_DATA, v); check("t6_accepted", v, 32'h8);
        rd(REG_CAPTURE, v); check("t6_no_cap", v, 32'h0);
        rd(REG_EDGE_EN, v); check("t6_edge_rst", v, 32'h0);
        wr(REG_EDGE_EN, 32'h8);
        pins = 4'b0011; tick(10);
        pins = 4'b1011; tick(10);
        rd(REG_CAPTURE, v); check("t6_cap_reprog", v, 32'h8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
